// File: rtl/output_layer_mac.sv
// rtl/output_layer_mac.sv - serial output-layer MAC with arg-max class/score
// One sign-magnitude term per cycle over 10 neurons x 30 activations.
module output_layer_mac #(
  parameter int N_OUT = 10,
  parameter int N_HID = 30,
  parameter int ACC_W = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_HID*8-1:0]      h,
  input  logic [N_HID*8-1:0]      wo0,
  input  logic [N_HID*8-1:0]      wo1,
  input  logic [N_HID*8-1:0]      wo2,
  input  logic [N_HID*8-1:0]      wo3,
  input  logic [N_HID*8-1:0]      wo4,
  input  logic [N_HID*8-1:0]      wo5,
  input  logic [N_HID*8-1:0]      wo6,
  input  logic [N_HID*8-1:0]      wo7,
  input  logic [N_HID*8-1:0]      wo8,
  input  logic [N_HID*8-1:0]      wo9,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              class_idx,
  output logic [ACC_W-1:0]        score
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam logic [4:0] K_LAST = 5'(N_HID - 1);
  localparam logic [3:0] N_LAST = 4'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state, state_nx;

  logic [N_HID*8-1:0]       h_lat;
  logic [3:0]               n;
  logic [4:0]               k;
  logic signed [ACC_W-1:0]  acc, acc_next, term;
  logic signed [ACC_W-1:0]  best_score, best_score_nx;
  logic [3:0]               best_idx, best_idx_nx;

  logic [N_HID*8-1:0]       wo_arr [N_OUT];
  logic [N_HID*8-1:0]       wsel;
  logic [7:0]               hb [N_HID];
  logic [7:0]               wb [N_HID];
  logic [7:0]               hbyte, wbyte;
  logic [14:0]              mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (k == K_LAST && n == N_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == MAC);
  assign done  = (state == DONE);

  // Weights are read live from the ports each cycle; only h is captured at start.
  always_comb begin
    wo_arr[0] = wo0; wo_arr[1] = wo1; wo_arr[2] = wo2; wo_arr[3] = wo3; wo_arr[4] = wo4;
    wo_arr[5] = wo5; wo_arr[6] = wo6; wo_arr[7] = wo7; wo_arr[8] = wo8; wo_arr[9] = wo9;
    wsel = (n <= N_LAST) ? wo_arr[n] : '0;
    for (int i = 0; i < N_HID; i++) begin
      hb[i] = h_lat[N_HID*8-1-8*i -: 8];
      wb[i] = wsel[N_HID*8-1-8*i -: 8];
    end
    hbyte = (k <= K_LAST) ? hb[k] : 8'd0;
    wbyte = (k <= K_LAST) ? wb[k] : 8'd0;
  end

  // Negative zero (0x80) has zero magnitude, so its negation is also zero.
  always_comb begin
    mag  = {7'd0, hbyte} * {8'd0, wbyte[6:0]};
    term = $signed({{(ACC_W-15){1'b0}}, mag});
    if (wbyte[7]) term = -term;
    acc_next = acc + term;
    best_score_nx = best_score;
    best_idx_nx   = best_idx;
    if (acc_next > best_score) begin
      best_score_nx = acc_next;
      best_idx_nx   = n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_lat      <= '0;
      n          <= '0;
      k          <= '0;
      acc        <= '0;
      best_score <= '0;
      best_idx   <= '0;
      class_idx  <= '0;
      score      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          h_lat      <= h;
          n          <= '0;
          k          <= '0;
          acc        <= '0;
          best_score <= MOST_NEG;
          best_idx   <= '0;
        end
        MAC: if (k == K_LAST) begin
          acc        <= '0;
          k          <= '0;
          n          <= n + 4'd1;
          best_score <= best_score_nx;
          best_idx   <= best_idx_nx;
          if (n == N_LAST) begin
            class_idx <= best_idx_nx;
            score     <= best_score_nx;
          end
        end else begin
          k   <= k + 5'd1;
          acc <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule
